tm_output_collector: RTL and testbench
======================================

Name: tm_output_collector

Overview:
- Parametrised output-collection stage at the tail of the configurable data path, after the bias adders.
- Accepts LANES biased features per beat, optionally applies ReLU, and writes them round-robin into Tm per-channel banks, addressed by pixel group.
- Signals completion of a tile and provides a 1-cycle-latency readback port for the downstream write-back engine.
- Generalises the fixed 2-lane (even/odd), fixed-Tm write path to LANES lanes, a runtime channel count, a runtime group count and a ReLU mode, and adds overflow error reporting.

Parameters:
Tm, 8, number of output-channel banks
LANES, 2, features per input beat (pixels processed in parallel)
FEATURE_WIDTH, 16, signed two's-complement feature width
DEPTH, 1024, words per bank; one word = LANES*FEATURE_WIDTH bits
ADDR_WIDTH, 10, bank address width; DEPTH <= 2**ADDR_WIDTH
CH_WIDTH, 3, channel index width; 2**CH_WIDTH >= Tm

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_en  in  1  one-cycle configuration strobe; accepted only in IDLE
cfg_num_ch_m1  in  CH_WIDTH  active channels minus 1; valid range 0..Tm-1
cfg_num_grp_m1  in  ADDR_WIDTH  pixel groups per channel minus 1; valid range 0..DEPTH-1
cfg_relu  in  1  1 = clamp negative lanes to 0
in_valid  in  1  input beat valid
in_data  in  LANES*FEATURE_WIDTH  lane k occupies bits [(k+1)*FW-1 : k*FW]
busy  out  1  high in COLLECT
done  out  1  one-cycle pulse after the final beat is written
err_overflow  out  1  sticky; set when in_valid arrives outside COLLECT; cleared by the next accepted cfg_en
rd_en  in  1  read strobe
rd_ch  in  CH_WIDTH  bank to read
rd_addr  in  ADDR_WIDTH  word address to read
rd_data  out  LANES*FEATURE_WIDTH  read data, registered
rd_valid  out  1  rd_en delayed by 1 cycle

Behaviour:
- Reset values:
  - busy = 0, done = 0, err_overflow = 0, rd_data = 0, rd_valid = 0.
  - State is IDLE; channel counter, group counter and latched configuration are all 0.
  - Bank contents are not reset.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - On cfg_en, latch cfg_num_ch_m1, cfg_num_grp_m1 and cfg_relu; clear both counters and err_overflow; go to COLLECT next cycle.
  - in_valid in IDLE sets err_overflow; data is dropped.
- COLLECT:
  - Each in_valid beat writes the processed in_data to bank[ch_cnt] at word grp_cnt, registered write (write at the clock edge).
  - Counter update on each beat: if ch_cnt == num_ch_m1, then ch_cnt <= 0 and grp_cnt <= grp_cnt+1; otherwise ch_cnt <= ch_cnt+1.
  - The beat where ch_cnt == num_ch_m1 and grp_cnt == num_grp_m1 is the final beat; the next state is DONE.
  - in_valid low stalls the counters; no write occurs.
  - cfg_en in COLLECT is ignored; the latched configuration is unchanged.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - in_valid in DONE sets err_overflow and is dropped.
  - cfg_en in DONE is ignored.
- ReLU: applied per lane when latched relu = 1. A lane whose MSB is 1 is written as 0; other lanes pass unchanged. No other arithmetic is performed; width is preserved.
- Read port:
  - rd_data is registered from bank[rd_ch][rd_addr] on rd_en; latency is 1 cycle; rd_data holds its value when rd_en = 0.
  - Read is independent of the FSM.
  - A same-cycle read and write to the same bank and address returns the old data (read-first).
  - rd_ch >= Tm returns 0.
- Minimum tile: with num_ch_m1 = 0 and num_grp_m1 = 0, one beat completes the tile.
- Throughput is 1 beat/cycle with no backpressure. Back-to-back tiles need 2 idle cycles (DONE, IDLE) plus cfg_en.
- rst asserted mid-COLLECT:
  - FSM returns to IDLE immediately and counters clear.
  - Partially written bank data remains; there is no done pulse.

Test Plan:
- Reset, then cfg_en with num_ch_m1=7, num_grp_m1=3, relu=0; drive 32 consecutive beats of lane0=i, lane1=i+100 -> bank[c] word g holds {g*8+c+100, g*8+c}; done pulses 1 cycle after beat 32; busy is high for exactly 32 cycles.
- relu=1, single beat of lane0=16'hFFF0 (-16), lane1=16'h0005 with num_ch_m1=0, num_grp_m1=0 -> bank0[0] = {0005, 0000}; done asserts after one beat.
- num_ch_m1=2, num_grp_m1=1, in_valid toggled 1/0 every cycle -> 6 writes land at (ch,grp) in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); done follows the 6th beat only.
- in_valid while IDLE -> err_overflow = 1 and no bank changes; a following cfg_en clears it to 0.
- rst asserted after 5 of 16 beats -> busy = 0 on the same edge, no done; a fresh cfg_en plus 16 beats completes normally.
- Read bank 3 addr 2 while writing the same location -> rd_valid=1 one cycle later with old data; a repeat read returns the new data; rd_ch=Tm returns 0.

Source files
------------

// File: rtl/tm_output_collector.sv
// Output-collection stage: takes LANES biased features per beat, optionally
// clamps negatives to zero, and scatters beats round-robin across Tm channel
// banks addressed by pixel group. Provides a registered readback port.
module tm_output_collector #(
   parameter int Tm            = 8,
   parameter int LANES         = 2,
   parameter int FEATURE_WIDTH = 16,
   parameter int DEPTH         = 1024,
   parameter int ADDR_WIDTH    = 10,
   parameter int CH_WIDTH      = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cfg_en,
   input  logic [CH_WIDTH-1:0]              cfg_num_ch_m1,
   input  logic [ADDR_WIDTH-1:0]            cfg_num_grp_m1,
   input  logic                             cfg_relu,
   input  logic                             in_valid,
   input  logic [LANES*FEATURE_WIDTH-1:0]   in_data,
   output logic                             busy,
   output logic                             done,
   output logic                             err_overflow,
   input  logic                             rd_en,
   input  logic [CH_WIDTH-1:0]              rd_ch,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [LANES*FEATURE_WIDTH-1:0]   rd_data,
   output logic                             rd_valid
);

   localparam int W = LANES * FEATURE_WIDTH;
   localparam logic [CH_WIDTH:0] TM_L = (CH_WIDTH+1)'(Tm);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t                  state_reg;
   logic [CH_WIDTH-1:0]     ch_cnt_reg;
   logic [ADDR_WIDTH-1:0]   grp_cnt_reg;
   logic [CH_WIDTH-1:0]     num_ch_reg;
   logic [ADDR_WIDTH-1:0]   num_grp_reg;
   logic                    relu_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    err_reg;

   logic                    wr_en;
   logic [W-1:0]            proc_data;
   logic [Tm-1:0][W-1:0]    bank_q;
   logic [CH_WIDTH-1:0]     rd_sel_reg;
   logic                    rd_hit_reg;
   logic                    rd_valid_reg;
   logic [W-1:0]            rd_mux;

   assign wr_en = (state_reg == COLLECT) && in_valid;

   // Per-lane ReLU: a negative lane (MSB set) is written as zero
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign proc_data[gi*FEATURE_WIDTH +: FEATURE_WIDTH] =
            (relu_reg && in_data[(gi+1)*FEATURE_WIDTH-1]) ? '0
                                                           : in_data[gi*FEATURE_WIDTH +: FEATURE_WIDTH];
      end
   endgenerate

   // Channel banks: write on the owning channel's beat, read-first registered read
   generate
      for (gi = 0; gi < Tm; gi++) begin : g_bank
         logic [W-1:0] mem [DEPTH];
         logic [W-1:0] q_reg;
         always_ff @(posedge clk) begin
            if (wr_en && (ch_cnt_reg == CH_WIDTH'(gi)))
               mem[grp_cnt_reg] <= proc_data;
            if (rd_en)
               q_reg <= mem[rd_addr];
         end
         assign bank_q[gi] = q_reg;
      end
   endgenerate

   // Collection FSM with counters, latched configuration and registered status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         ch_cnt_reg  <= '0;
         grp_cnt_reg <= '0;
         num_ch_reg  <= '0;
         num_grp_reg <= '0;
         relu_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cfg_en) begin
                  num_ch_reg  <= cfg_num_ch_m1;
                  num_grp_reg <= cfg_num_grp_m1;
                  relu_reg    <= cfg_relu;
                  ch_cnt_reg  <= '0;
                  grp_cnt_reg <= '0;
                  err_reg     <= 1'b0;
                  busy_reg    <= 1'b1;
                  state_reg   <= COLLECT;
               end else if (in_valid) begin
                  err_reg <= 1'b1;
               end
            end
            COLLECT: begin
               if (in_valid) begin
                  if (ch_cnt_reg == num_ch_reg) begin
                     ch_cnt_reg  <= '0;
                     grp_cnt_reg <= grp_cnt_reg + ADDR_WIDTH'(1);
                     if (grp_cnt_reg == num_grp_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                     end
                  end else begin
                     ch_cnt_reg <= ch_cnt_reg + CH_WIDTH'(1);
                  end
               end
            end
            DONE: begin
               if (in_valid)
                  err_reg <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Read-side bookkeeping: remember which bank was read and whether it exists
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_sel_reg   <= '0;
         rd_hit_reg   <= 1'b0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en) begin
            rd_sel_reg <= rd_ch;
            rd_hit_reg <= ({1'b0, rd_ch} < TM_L);
         end
      end
   end

   // Select the registered word of the bank that was read
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < Tm; i++)
         if (rd_sel_reg == CH_WIDTH'(i))
            rd_mux = bank_q[i];
   end

   assign rd_data      = rd_hit_reg ? rd_mux : '0;
   assign rd_valid     = rd_valid_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign err_overflow = err_reg;

endmodule

// File: tb/tb_tm_output_collector.sv
// Scoreboard bench for tm_output_collector: stimulus pushes expected read
// words into a queue, a negedge monitor pops and compares on rd_valid.
module tb_tm_output_collector;

   localparam int TM = 8;
   localparam int LN = 2;
   localparam int FW = 16;
   localparam int DP = 16;
   localparam int AW = 4;
   localparam int CW = 4;
   localparam int W  = LN * FW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_en = 1'b0;
   logic [CW-1:0] cfg_num_ch_m1 = '0;
   logic [AW-1:0] cfg_num_grp_m1 = '0;
   logic          cfg_relu = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          busy, done, err_overflow;
   logic          rd_en = 1'b0;
   logic [CW-1:0] rd_ch = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [W-1:0]  rd_data;
   logic          rd_valid;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   string        name_q[$];

   tm_output_collector #(
      .Tm(TM), .LANES(LN), .FEATURE_WIDTH(FW), .DEPTH(DP),
      .ADDR_WIDTH(AW), .CH_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_en(cfg_en), .cfg_num_ch_m1(cfg_num_ch_m1),
      .cfg_num_grp_m1(cfg_num_grp_m1), .cfg_relu(cfg_relu),
      .in_valid(in_valid), .in_data(in_data),
      .busy(busy), .done(done), .err_overflow(err_overflow),
      .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   // Monitor: every rd_valid cycle consumes one expected word
   always @(negedge clk) begin
      if (rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected got=%h required=none", rd_data);
         end else begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL %s got=%h required=%h", n, rd_data, e);
            end else
               $display("read %s data=%h ok", n, rd_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string n, input logic [W-1:0] got, input logic [W-1:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", n, got, req);
      end else
         $display("check %s value=%h ok", n, got);
   endtask

   task automatic cfg(input int ch_m1, input int grp_m1, input logic relu);
      cfg_en = 1'b1;
      cfg_num_ch_m1 = CW'(ch_m1);
      cfg_num_grp_m1 = AW'(grp_m1);
      cfg_relu = relu;
      tick();
      cfg_en = 1'b0;
   endtask

   // Issue a one-cycle read and record the word it must return
   task automatic rd(input int ch, input int addr, input logic [W-1:0] e, input string n);
      rd_en = 1'b1;
      rd_ch = CW'(ch);
      rd_addr = AW'(addr);
      exp_q.push_back(e);
      name_q.push_back(n);
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      int done_early;

      // Reset state
      #12;
      check("reset_busy", W'(busy), W'(0));
      check("reset_done", W'(done), W'(0));
      check("reset_err", W'(err_overflow), W'(0));
      check("reset_rd_valid", W'(rd_valid), W'(0));
      check("reset_rd_data", rd_data, W'(0));
      rst = 1'b0;
      tick();

      // Tile 1: 8 channels x 4 groups, lane0=i, lane1=i+100
      cfg(7, 3, 1'b0);
      busy_cycles = 0;
      done_early = 0;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_data = {16'(i + 100), 16'(i)};
         if (busy) busy_cycles++;
         if (done) done_early++;
         tick();
      end
      in_valid = 1'b0;
      check("t1_done_pulse", W'(done), W'(1));
      check("t1_busy_low", W'(busy), W'(0));
      check("t1_busy_cycles", W'(busy_cycles), W'(32));
      check("t1_no_early_done", W'(done_early), W'(0));
      tick();
      check("t1_done_one_cycle", W'(done), W'(0));
      rd(0, 0, 32'h0064_0000, "t1_b0_g0");
      rd(7, 3, 32'h0083_001F, "t1_b7_g3");
      rd(3, 2, 32'h0077_0013, "t1_b3_g2");
      rd(5, 1, 32'h0071_000D, "t1_b5_g1");
      tick();

      // Tile 2: ReLU minimum tile
      cfg(0, 0, 1'b1);
      in_valid = 1'b1;
      in_data = 32'h0005_FFF0;
      tick();
      in_valid = 1'b0;
      check("t2_done_single_beat", W'(done), W'(1));
      tick();
      rd(0, 0, 32'h0005_0000, "t2_relu_b0_g0");
      rd(1, 0, 32'h0065_0001, "t2_b1_untouched");

      // Tile 3: 3 channels x 2 groups with in_valid toggling
      cfg(2, 1, 1'b0);
      for (int j = 0; j < 6; j++) begin
         in_valid = 1'b1;
         in_data = {16'(j + 200), 16'(j + 50)};
         tick();
         in_valid = 1'b0;
         check($sformatf("t3_done_beat%0d", j), W'(done), W'(j == 5));
         tick();
      end
      rd(0, 0, 32'h00C8_0032, "t3_c0_g0");
      rd(1, 0, 32'h00C9_0033, "t3_c1_g0");
      rd(2, 0, 32'h00CA_0034, "t3_c2_g0");
      rd(0, 1, 32'h00CB_0035, "t3_c0_g1");
      rd(1, 1, 32'h00CC_0036, "t3_c1_g1");
      rd(2, 1, 32'h00CD_0037, "t3_c2_g1");
      tick();

      // Overflow in IDLE: error sets, bank untouched, cfg_en clears it
      check("t4_err_before", W'(err_overflow), W'(0));
      in_valid = 1'b1;
      in_data = 32'hDEAD_BEEF;
      tick();
      in_valid = 1'b0;
      check("t4_err_set", W'(err_overflow), W'(1));
      rd(0, 0, 32'h00C8_0032, "t4_b0_g0_unchanged");
      cfg(3, 3, 1'b0);
      check("t4_err_cleared", W'(err_overflow), W'(0));

      // Reset after 5 of 16 beats
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data = {16'(k + 300), 16'(k + 1000)};
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t5_busy_async_clear", W'(busy), W'(0));
      tick();
      rst = 1'b0;
      done_early = 0;
      for (int n = 0; n < 3; n++) begin
         if (done) done_early++;
         tick();
      end
      check("t5_no_done_after_rst", W'(done_early), W'(0));
      rd(1, 0, 32'h012D_03E9, "t5_partial_kept");
      cfg(3, 3, 1'b0);
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1;
         in_data = {16'(k + 400), 16'(k)};
         tick();
      end
      in_valid = 1'b0;
      check("t5_done_after_16", W'(done), W'(1));
      tick();
      rd(0, 1, 32'h0194_0004, "t5_b0_g1");
      rd(3, 3, 32'h019F_000F, "t5_b3_g3");

      // Read-during-write at bank 3 word 2, then out-of-range bank
      cfg(3, 2, 1'b0);
      for (int k = 0; k < 12; k++) begin
         in_valid = 1'b1;
         in_data = {16'(k + 500), 16'(k + 600)};
         if (k == 11) begin
            rd_en = 1'b1;
            rd_ch = 4'd3;
            rd_addr = 4'd2;
            exp_q.push_back(32'h019B_000B);
            name_q.push_back("t6_read_first_old");
         end
         tick();
      end
      in_valid = 1'b0;
      rd_en = 1'b0;
      check("t6_done", W'(done), W'(1));
      rd(3, 2, 32'h01FF_0263, "t6_reread_new");
      rd(8, 0, 32'h0000_0000, "t6_rd_ch_tm_zero");
      tick();
      check("t6_rd_valid_low", W'(rd_valid), W'(0));
      check("t6_rd_data_held", rd_data, W'(0));

      // Drain the scoreboard within a bounded number of cycles
      for (int n = 0; n < 10 && exp_q.size() > 0; n++) tick();
      check("scoreboard_drained", W'(exp_q.size()), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
